// File: rtl/dmem_pkg.sv
// Shared definitions for the M-stage data-memory access unit: funct3 codes,
// FSM state encoding and the store-lane helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    // Byte enables for a store; lanes shifted past byte 3 fall off the word.
    function automatic logic [3:0] wstrb_of(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << addr_lo;
            2'b01:   strb = 4'b0011 << addr_lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] data;
        case (funct3[1:0])
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Combinational load formatter: picks the addressed byte/halfword from the raw
// bus word and sign- or zero-extends it to 32 bits.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] raw_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        // Bring the addressed lane down to bit 0; bytes beyond the word read as zero.
        shifted  = raw_i >> {addr_lo_i, 3'b000};
        result_o = raw_i;
        case (funct3_i)
            F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result_o = {24'h0, shifted[7:0]};
            F3_HU:   result_o = {16'h0, shifted[15:0]};
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// M-stage data-memory master: valid/ready request, response wait with timeout,
// load alignment and stall request. Optional DMEM_MISALIGN_CHECK_EN rejects misaligned H/W accesses.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [2:0]        funct3_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [31:0]       wdata_m,
    output logic [31:0]       rdata_m,
    output logic              stall_mem_m,
    output logic              bus_err_m,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [31:0]       req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [31:0]       resp_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;

    logic              acc;
    logic              misalign;
    logic              timeout_hit;
    logic [31:0]       load_result;

    assign acc = mem_read_m | mem_write_m;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = misaligned(funct3_m, addr_m[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

    dmem_load_extend u_load_extend (
        .funct3_i  (funct3_m),
        .addr_lo_i (addr_m[1:0]),
        .raw_i     (resp_rdata),
        .result_o  (load_result)
    );

    // Request fields come straight from the M-stage inputs, which the stall holds stable.
    assign req_we    = mem_write_m;
    assign req_addr  = {addr_m[ADDR_W-1:2], 2'b00};
    assign req_wdata = store_data(funct3_m, wdata_m);
    assign req_wstrb = wstrb_of(funct3_m, addr_m[1:0]);

    // Gated by rst so a reset mid-access drops the request and stall in the same cycle.
    assign req_valid   = ~rst & (((state_q == IDLE) & acc & ~misalign) | (state_q == REQ));
    assign stall_mem_m = ~rst & (((state_q == IDLE) & acc) | (state_q == REQ) | (state_q == WAIT));
    assign rdata_m     = rdata_q;
    assign bus_err_m   = bus_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (misalign) begin
                        state_d   = DONE;
                        bus_err_d = 1'b1;
                        rdata_d   = '0;
                    end else if (req_ready) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // A response arriving in the limit cycle still wins over the timeout.
                if (resp_valid) begin
                    state_d = DONE;
                    if (!mem_write_m) begin
                        rdata_d = load_result;
                    end
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench for dmem_access_unit: acts as the bus slave and compares each
// access against a byte-level model of stall length, handshakes, fields and load data.
module tb_dmem_access_unit;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read_m, mem_write_m;
    logic [2:0]    funct3_m;
    logic [AW-1:0] addr_m;
    logic [31:0]   wdata_m;
    logic [31:0]   rdata_m;
    logic          stall_mem_m, bus_err_m;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          resp_valid;
    logic [31:0]   resp_rdata;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .addr_m(addr_m), .wdata_m(wdata_m),
        .rdata_m(rdata_m), .stall_mem_m(stall_mem_m), .bus_err_m(bus_err_m),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata)
    );

    int          checks = 0;
    int          errors = 0;
    int          txn    = 0;
    logic [31:0] model_rdata = 32'h0;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (txn %0d)", tag, obs, exp, txn);
        end
    endtask

    // One full access as seen by the M stage; the bus slave accepts after rdy_dly
    // valid cycles and responds rsp_dly cycles after the handshake (never if no_resp).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rword, input int rdy_dly,
                              input int rsp_dly, input bit no_resp, input bit gap);
        int a, sz, exp_stall, stall_cyc, valid_cyc, hs_cnt, err_cnt, field_bad, wcnt, cyc;
        bit uns, mis, err, hs, started, done;
        logic [31:0] exp_wdata, exp_load, exp_rdata;
        logic [3:0]  exp_strb;

        a   = int'(addr[1:0]);
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        uns = f3[2];
        mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = (a % sz) != 0;
`endif
        err = mis || no_resp;

        exp_strb = 4'h0;
        if (sz == 4) exp_strb = 4'hF;
        else for (int i = 0; i < 4; i++) if (i >= a && i < a + sz) exp_strb[i] = 1'b1;
        case (sz)
            1:       exp_wdata = {4{wd[7:0]}};
            2:       exp_wdata = {2{wd[15:0]}};
            default: exp_wdata = wd;
        endcase
        exp_load = 32'h0;
        if (sz == 4) exp_load = rword;
        else begin
            for (int i = 0; i < sz; i++) if (a + i < 4) exp_load[8*i +: 8] = rword[8*(a+i) +: 8];
            if (!uns && exp_load[8*sz-1]) for (int i = 8*sz; i < 32; i++) exp_load[i] = 1'b1;
        end
        exp_stall = mis ? 1 : 1 + rdy_dly + (no_resp ? TO + 1 : rsp_dly + 1);
        exp_rdata = err ? 32'h0 : (wr ? model_rdata : exp_load);

        stall_cyc = 0; valid_cyc = 0; hs_cnt = 0; err_cnt = 0; field_bad = 0; wcnt = 0; cyc = 0;
        hs = 1'b0; started = 1'b0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            mem_read_m = rd; mem_write_m = wr; funct3_m = f3; addr_m = addr; wdata_m = wd;
            req_ready = !hs && (valid_cyc == rdy_dly);
            if (hs) begin
                resp_valid = !no_resp && (wcnt == rsp_dly);
                resp_rdata = resp_valid ? rword : $urandom();
                wcnt++;
            end else begin
                resp_valid = 1'($urandom_range(0, 1));
                resp_rdata = $urandom();
            end
            #1;
            if (bus_err_m) err_cnt++;
            if (req_valid) begin
                valid_cyc++;
                if (req_we !== wr || req_addr !== {addr[31:2], 2'b00}) field_bad++;
                if (wr && (req_wdata !== exp_wdata || req_wstrb !== exp_strb)) field_bad++;
                if (req_ready) begin
                    hs_cnt++;
                    hs = 1'b1;
                end
            end
            if (stall_mem_m) begin
                stall_cyc++;
                started = 1'b1;
            end else if (started) begin
                done = 1'b1;
                check_eq("rdata_done", rdata_m, exp_rdata);
            end
            cyc++;
        end
        check_eq("done_reached", 32'(done), 32'd1);
        check_eq("stall_cycles", stall_cyc, exp_stall);
        check_eq("valid_cycles", valid_cyc, mis ? 0 : rdy_dly + 1);
        check_eq("handshakes", hs_cnt, mis ? 0 : 1);
        check_eq("field_errs", field_bad, 0);
        check_eq("err_pulses", err_cnt, err ? 1 : 0);
        model_rdata = exp_rdata;
        $display("txn %0d rd=%0b wr=%0b f3=%0d addr=0x%08h rdy=%0d rsp=%0d noresp=%0b stall=%0d rdata=0x%08h",
                 txn, rd, wr, f3, addr, rdy_dly, rsp_dly, no_resp, stall_cyc, rdata_m);
        txn++;

        if (gap) begin
            @(negedge clk);
            mem_read_m = 1'b0; mem_write_m = 1'b0;
            req_ready  = 1'($urandom_range(0, 1));
            resp_valid = 1'($urandom_range(0, 1));
            #1;
            check_eq("idle_quiet", {29'h0, stall_mem_m, req_valid, bus_err_m}, 32'h0);
            check_eq("idle_rdata", rdata_m, model_rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       rd, wr;
        logic [2:0] f3;
        int         kind;

        rst = 1'b1;
        mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'd0; addr_m = '0; wdata_m = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_rdata", rdata_m, 32'h0);
        check_eq("rst_outs", {29'h0, stall_mem_m, req_valid, bus_err_m}, 32'h0);
        mem_read_m = 1'b1;
        #1;
        check_eq("rst_gates_stall", {30'h0, stall_mem_m, req_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0; mem_read_m = 1'b0;

        // Directed cases from the block's reference scenarios.
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 1'b1);
        check_eq("lw_min_latency", rdata_m, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, 1'b0, 1'b0);
        check_eq("lb_sext", rdata_m, 32'hFFFFFF80);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, 1'b0, 1'b1);
        check_eq("lbu_zext", rdata_m, 32'h00000080);
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 2, 1'b0, 1'b1);
        check_eq("sh_keeps_rdata", rdata_m, 32'h00000080);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 3, 1, 1'b0, 1'b1);
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h5555AAAA, 1, 0, 1'b1, 1'b1);
        check_eq("timeout_rdata", rdata_m, 32'h0);
        run_access(1'b1, 1'b1, 3'b000, 32'h201, 32'hA5A5A5C3, 32'h0, 0, 0, 1'b0, 1'b0);

        // Reset while waiting for the response.
        @(negedge clk);
        mem_read_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010; addr_m = 32'h200;
        req_ready = 1'b1; resp_valid = 1'b0;
        #1;
        check_eq("rstw_issue", 32'(req_valid), 32'd1);
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        check_eq("rstw_waiting", {30'h0, stall_mem_m, req_valid}, 32'h2);
        rst = 1'b1;
        #1;
        check_eq("rstw_immediate", {30'h0, stall_mem_m, req_valid}, 32'h0);
        @(negedge clk);
        mem_read_m = 1'b0; resp_valid = 1'b1; resp_rdata = 32'hCAFEF00D;
        #1;
        check_eq("rstw_rdata_cleared", rdata_m, 32'h0);
        model_rdata = 32'h0;
        rst = 1'b0; resp_valid = 1'b0;
        run_access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h13579BDF, 0, 0, 1'b0, 1'b1);
        check_eq("post_rst_lw", rdata_m, 32'h13579BDF);
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h2468ACE0, 0, 0, 1'b0, 1'b1);

        // Random mix of loads, stores and occasional timeouts.
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            rd = (kind <= 5) || (kind == 9);
            wr = (kind >= 6);
            f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            run_access(rd, wr, f3, $urandom(), $urandom(), $urandom(),
                       $urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
